// File: rtl/seq_scan_pkg.sv
// Shared encodings for the serial 1011 scanner: detector states, controller
// states, the pattern constant and the detector next-state function.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        DET_S0   = 2'b00,
        DET_S1   = 2'b01,
        DET_S10  = 2'b11,
        DET_S101 = 2'b10
    } det_state_t;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'b00,
        CTRL_SHIFT = 2'b01,
        CTRL_DONE  = 2'b10
    } ctrl_state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

    // Overlapping detection: after a hit the trailing 1 restarts the prefix in S1.
    function automatic det_state_t det_next(input det_state_t s, input logic w);
        det_state_t n;
        case (s)
            DET_S0:   n = w ? DET_S1   : DET_S0;
            DET_S1:   n = w ? DET_S1   : DET_S10;
            DET_S10:  n = w ? DET_S101 : DET_S0;
            DET_S101: n = w ? DET_S1   : DET_S10;
            default:  n = DET_S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pattern_fsm.sv
// Mealy detector for the serial pattern 1011; z is combinational on the
// current state and input bit, the state only advances while en is high.
module pattern_fsm
    import seq_scan_pkg::*;
(
    input  logic Clock,
    input  logic Resetn,
    input  logic clr,
    input  logic en,
    input  logic w,
    output logic z
);

    det_state_t r_state;

    // Detector state register: reset and clr both return to S0, en gates advance.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= DET_S0;
        end else if (clr) begin
            r_state <= DET_S0;
        end else if (en) begin
            r_state <= det_next(r_state, w);
        end else begin
            r_state <= r_state;
        end
    end

    assign z = (r_state == DET_S101) & w & en;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word scanner: captures a DATA_W word, streams it MSB first through the 1011
// detector, and presents the match count and first-match index on a handshake.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_hit,
    output logic [CNT_W-1:0]  out_first,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    ctrl_state_t       r_state;
    logic [DATA_W-1:0] r_word;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_first;
    logic              r_hit;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic              w_accept;
    logic              w_en;
    logic              w_z;
    logic              w_det_clr;
    logic [DATA_W-1:0] w_shifted;
    logic              w_bit;

    // clr wins over a simultaneous offer so an aborted cycle never accepts a word.
    assign w_accept  = (r_state == CTRL_IDLE) & r_in_ready & in_valid & ~clr;
    assign w_en      = (r_state == CTRL_SHIFT);
    assign w_det_clr = clr | w_accept;
    assign w_shifted = r_word << r_idx;
    assign w_bit     = w_shifted[DATA_W-1];

    pattern_fsm u_pattern_fsm (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (w_det_clr),
        .en     (w_en),
        .w      (w_bit),
        .z      (w_z)
    );

    // Controller FSM with all handshake and result outputs registered.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state     <= CTRL_IDLE;
            r_word      <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_first     <= '0;
            r_hit       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (clr) begin
            r_state     <= CTRL_IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            r_first     <= '0;
            r_hit       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                CTRL_IDLE: begin
                    if (w_accept) begin
                        r_state    <= CTRL_SHIFT;
                        r_word     <= in_data;
                        r_idx      <= '0;
                        r_count    <= '0;
                        r_first    <= '0;
                        r_hit      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= CTRL_IDLE;
                    end
                end
                CTRL_SHIFT: begin
                    if (w_z) begin
                        r_count <= r_count + CNT_W'(1);
                        r_hit   <= 1'b1;
                        if (r_count == '0) begin
                            r_first <= r_idx;
                        end else begin
                            r_first <= r_first;
                        end
                    end else begin
                        r_count <= r_count;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state     <= CTRL_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                CTRL_DONE: begin
                    // in_ready rises only after the handshake edge, never inside DONE.
                    if (out_ready) begin
                        r_state     <= CTRL_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state <= CTRL_DONE;
                    end
                end
                default: begin
                    r_state     <= CTRL_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_count = r_count;
    assign out_hit   = r_hit;
    assign out_first = r_first;
    assign busy      = r_busy;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed words, abort/reset cases and
// random words compared against a sliding-window pattern count model.
module tb_seq_scan_ctrl;

    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_count;
    logic          out_hit;
    logic [CW-1:0] out_first;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt;
    int exp_first;

    seq_scan_ctrl #(.DATA_W(DW)) dut (
        .Clock     (clk),
        .Resetn    (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_hit   (out_hit),
        .out_first (out_first),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: count every 4-bit window (MSB-first bit order) equal to 1011.
    function automatic void ref_scan(input logic [DW-1:0] d, output int cnt, output int first);
        logic [3:0] win;
        cnt   = 0;
        first = 0;
        for (int i = 3; i < DW; i++) begin
            win = {d[DW-1-(i-3)], d[DW-1-(i-2)], d[DW-1-(i-1)], d[DW-1-i]};
            if (win == 4'b1011) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_to_done(input logic [DW-1:0] d);
        logic bad = 1'b0;
        wait_ready();
        ref_scan(d, exp_cnt, exp_first);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
        for (int k = 1; k < DW; k++) begin
            step();
            if (out_valid || in_ready || !busy) bad = 1'b1;
        end
        chk("shift_quiet", {31'd0, bad}, 32'd0);
        step();
        chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
        chk("out_count", 32'(out_count), 32'(exp_cnt));
        chk("out_hit", {31'd0, out_hit}, (exp_cnt != 0) ? 32'd1 : 32'd0);
        chk("out_first", 32'(out_first), 32'(exp_first));
    endtask

    task automatic handshake(input int delay);
        for (int d = 0; d < delay; d++) begin
            out_ready = 1'b0;
            step();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_count", 32'(out_count), 32'(exp_cnt));
            chk("hold_first", 32'(out_first), 32'(exp_first));
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'($urandom);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("valid_drop", {31'd0, out_valid}, 32'd0);
        chk("in_ready_rise", {31'd0, in_ready}, 32'd1);
        chk("no_accept_in_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_hit", {31'd0, out_hit}, 32'd0);
        chk("rst_first", 32'(out_first), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        step();

        run_to_done(8'hB0); handshake(0);
        run_to_done(8'hB6); handshake(1);
        run_to_done(8'hBB); handshake(0);
        run_to_done(8'h00); handshake(0);
        run_to_done(8'h2D); handshake(0);
        run_to_done(8'hB6); handshake(5);

        // Reset while at SHIFT index 4 discards the word.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'hB6;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        run_to_done(8'hB0); handshake(0);

        // clr with an offer in IDLE accepts nothing.
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hB0;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_idle_busy", {31'd0, busy}, 32'd0);
        chk("clr_idle_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("clr_idle_still_idle", {31'd0, busy}, 32'd0);

        // clr in DONE drops the result.
        run_to_done(8'hBB);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_done_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_done_count", 32'(out_count), 32'd0);
        chk("clr_done_first", 32'(out_first), 32'd0);
        chk("clr_done_in_ready", {31'd0, in_ready}, 32'd1);

        for (int r = 0; r < 40; r++) begin
            run_to_done(DW'($urandom));
            handshake(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
